// File: rtl/act_quant_stage.sv
// Activation quantization stage: converts 16-bit accumulator results to saturated int8 and
// buffers them in a small FIFO with vector framing (m_last) and a saturation counter.
module act_quant_stage #(
    parameter int DEPTH   = 4,
    parameter int VEC_LEN = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] s_data,
    input  logic               s_overflow,
    input  logic               relu_en,
    input  logic [3:0]         shift,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [7:0]  m_data,
    output logic               m_sat,
    output logic               m_last,
    output logic [7:0]         sat_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int VW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);
    localparam logic [VW-1:0] VEC_MAX   = VW'(VEC_LEN - 1);

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [OW-1:0] occ_reg, occ_next;
    logic [VW-1:0] vec_cnt_reg;
    logic [7:0]    sat_count_reg;
    logic [9:0]    fifo_mem [DEPTH];

    logic               push, pop;
    logic signed [7:0]  q_data;
    logic               q_sat;
    logic signed [16:0] x_ext, round_add, sum, shifted;
    logic [9:0]         wr_entry;

    assign s_ready   = (occ_reg < DEPTH_OCC);
    assign m_valid   = (occ_reg != '0);
    assign push      = s_valid && s_ready;
    assign pop       = m_valid && m_ready;
    assign sat_count = sat_count_reg;

    // Quantizer: overflow forces saturation toward the true sign, which is the
    // opposite of the wrapped sign bit; otherwise ReLU, round-half-up shift, clamp.
    always_comb begin
        q_data    = '0;
        q_sat     = 1'b0;
        x_ext     = {s_data[15], s_data};
        round_add = '0;
        sum       = '0;
        shifted   = '0;
        if (s_overflow) begin
            q_data = s_data[15] ? 8'sh7F : 8'sh80;
            q_sat  = 1'b1;
        end else begin
            if (relu_en && s_data[15])
                x_ext = '0;
            if (shift != 4'd0)
                round_add = 17'sd1 <<< (shift - 4'd1);
            sum     = x_ext + round_add;
            shifted = sum >>> shift;
            if (shifted > 17'sd127) begin
                q_data = 8'sh7F;
                q_sat  = 1'b1;
            end else if (shifted < -17'sd128) begin
                q_data = 8'sh80;
                q_sat  = 1'b1;
            end else begin
                q_data = shifted[7:0];
            end
        end
    end

    assign wr_entry = {(vec_cnt_reg == VEC_MAX), q_sat, q_data};

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            vec_cnt_reg   <= '0;
            sat_count_reg <= '0;
        end else begin
            occ_reg <= occ_next;
            if (push) begin
                wr_ptr_reg  <= wr_ptr_reg + 1'b1;
                vec_cnt_reg <= (vec_cnt_reg == VEC_MAX) ? '0 : vec_cnt_reg + 1'b1;
                if (q_sat && sat_count_reg != 8'hFF)
                    sat_count_reg <= sat_count_reg + 8'd1;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= wr_entry;
    end

    assign {m_last, m_sat, m_data} = fifo_mem[rd_ptr_reg];

endmodule

// File: tb/tb_act_quant_stage.sv
// Scoreboard bench for act_quant_stage: expected outputs are queued on acceptance
// and compared in order when the stage hands results downstream.
module tb_act_quant_stage;
    localparam int DEPTH   = 4;
    localparam int VEC_LEN = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic               s_overflow;
    logic               relu_en;
    logic [3:0]         shift;
    logic               m_valid;
    logic               m_ready;
    logic signed [7:0]  m_data;
    logic               m_sat;
    logic               m_last;
    logic [7:0]         sat_count;

    act_quant_stage #(.DEPTH(DEPTH), .VEC_LEN(VEC_LEN)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_overflow(s_overflow),
        .relu_en(relu_en), .shift(shift),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
        .m_last(m_last), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] d;
        logic               o;
        logic               r;
        logic [3:0]         s;
    } stim_t;

    stim_t      stim_q[$];
    logic [9:0] exp_q[$];
    int         tb_vec;
    int         tb_sat;
    int         n_cmp;
    int         n_err;

    function automatic stim_t mk(input int d, input bit o, input bit r, input int s);
        stim_t st;
        st.d = 16'(d);
        st.o = o;
        st.r = r;
        st.s = 4'(s);
        return st;
    endfunction

    // Reference quantizer: {sat, data}, rounding done in real arithmetic.
    function automatic logic [8:0] quant(input int d, input bit o, input bit r, input int sh);
        int x;
        int q;
        if (o)
            return (d < 0) ? {1'b1, 8'h7F} : {1'b1, 8'h80};
        x = (r && d < 0) ? 0 : d;
        q = int'($floor(real'(x) / real'(2 ** sh) + 0.5));
        if (q > 127)  return {1'b1, 8'h7F};
        if (q < -128) return {1'b1, 8'h80};
        return {1'b0, 8'(q)};
    endfunction

    function automatic void model_accept(input stim_t st);
        logic [8:0] e;
        e = quant(int'(st.d), st.o, st.r, int'(st.s));
        exp_q.push_back({(tb_vec == VEC_LEN - 1), e});
        tb_vec = (tb_vec + 1) % VEC_LEN;
        if (e[8] && tb_sat < 255)
            tb_sat++;
    endfunction

    task automatic drive(input stim_t st);
        s_valid    = 1'b1;
        s_data     = st.d;
        s_overflow = st.o;
        relu_en    = st.r;
        shift      = st.s;
    endtask

    task automatic idle();
        s_valid    = 1'b0;
        s_data     = 'x;
        s_overflow = 'x;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        m_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        tb_vec = 0;
        tb_sat = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++;
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_cmp++;
        if (sat_count !== 8'd0) begin n_err++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
    endtask

    // Streams stim_q through the DUT with random valid/ready duty and scores every output.
    task automatic test_stream(input string name, input int v_pct, input int r_pct);
        int         cyc;
        int         outs;
        logic [9:0] exp;
        cyc  = 0;
        outs = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            if (stim_q.size() > 0 && $urandom_range(0, 99) < v_pct) drive(stim_q[0]);
            else idle();
            m_ready = ($urandom_range(0, 99) < r_pct);
            #1;
            if (m_valid && m_ready) begin
                n_cmp++;
                outs++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s_extra: got unexpected output data=%0d want none", name, m_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({m_last, m_sat, m_data} !== exp) begin
                        n_err++;
                        $display("FAIL %s_out%0d: got last=%b sat=%b data=%0d want last=%b sat=%b data=%0d",
                                 name, outs, m_last, m_sat, m_data, exp[9], exp[8], $signed(exp[7:0]));
                    end
                end
            end
            if (s_valid && s_ready)
                model_accept(stim_q.pop_front());
            cyc++;
        end
        @(negedge clk);
        idle();
        m_ready = 1'b0;
        #1;
        n_cmp++;
        if (stim_q.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d unsent / %0d pending want 0 / 0", name, stim_q.size(), exp_q.size());
            stim_q.delete();
            exp_q.delete();
        end
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL %s_drained: got m_valid=%b want 0", name, m_valid); end
        n_cmp++;
        if (sat_count !== 8'(tb_sat)) begin n_err++; $display("FAIL %s_sat_count: got %0d want %0d", name, sat_count, tb_sat); end
        $display("%s: %0d outputs scored", name, outs);
    endtask

    task automatic test_transform();
        do_reset();
        stim_q.push_back(mk(100, 0, 0, 0));
        stim_q.push_back(mk(186, 0, 0, 0));
        stim_q.push_back(mk(1012, 0, 0, 4));
        stim_q.push_back(mk(808, 0, 0, 4));
        stim_q.push_back(mk(-494, 0, 0, 4));
        stim_q.push_back(mk(4191, 0, 0, 4));
        stim_q.push_back(mk(-17149, 1, 0, 0));
        stim_q.push_back(mk(-210, 0, 1, 0));
        stim_q.push_back(mk(32767, 0, 0, 15));
        stim_q.push_back(mk(-32768, 0, 0, 8));
        test_stream("transform", 100, 100);
    endtask

    task automatic test_backpressure();
        stim_t      bp[5];
        int         k;
        int         outs;
        logic [9:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) bp[i] = mk(10 * (i + 1), 0, 0, 0);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (k < 5) drive(bp[k]); else idle();
            m_ready = 1'b0;
            #1;
            if (s_valid && s_ready) begin model_accept(bp[k]); k++; end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (k != 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", k); end
        n_cmp++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_s_ready: got %b want 0", s_ready); end
        n_cmp++;
        if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_full_m_valid: got %b want 1", m_valid); end
        outs = 0;
        for (int c = 0; c < 30 && (k < 5 || exp_q.size() > 0); c++) begin
            @(negedge clk);
            if (k < 5) drive(bp[k]); else idle();
            m_ready = 1'b1;
            #1;
            if (c == 0) begin
                n_cmp++;
                if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_bypass: got s_ready=%b want 0", s_ready); end
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                outs++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: got data=%0d want none", m_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({m_last, m_sat, m_data} !== exp) begin
                        n_err++;
                        $display("FAIL bp_out%0d: got last=%b sat=%b data=%0d want last=%b sat=%b data=%0d",
                                 outs, m_last, m_sat, m_data, exp[9], exp[8], $signed(exp[7:0]));
                    end
                end
            end
            if (s_valid && s_ready) begin model_accept(bp[k]); k++; end
        end
        @(negedge clk);
        idle();
        m_ready = 1'b0;
        n_cmp++;
        if (outs != 5) begin n_err++; $display("FAIL bp_out_count: got %0d want 5", outs); end
        $display("backpressure: %0d outputs scored", outs);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 9; i++)
            stim_q.push_back(mk(int'($signed(16'($urandom))), ($urandom_range(0, 9) == 0),
                                1'($urandom_range(0, 1)), int'($urandom_range(0, 15))));
        test_stream("random", 60, 50);
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            @(negedge clk);
            drive(mk(-300, 1, 0, 0));
            m_ready = 1'b0;
            #1;
            if (s_valid && s_ready) begin model_accept(mk(-300, 1, 0, 0)); k++; end
        end
        @(negedge clk);
        reset   = 1'b1;
        m_ready = 1'b1;
        drive(mk(5000, 1, 0, 0));
        @(negedge clk);
        reset   = 1'b0;
        m_ready = 1'b0;
        idle();
        exp_q.delete();
        tb_vec = 0;
        tb_sat = 0;
        #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL midreset_m_valid: got %b want 0", m_valid); end
        n_cmp++;
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL midreset_s_ready: got %b want 1", s_ready); end
        n_cmp++;
        if (sat_count !== 8'd0) begin n_err++; $display("FAIL midreset_sat_count: got %0d want 0", sat_count); end
        stim_q.push_back(mk(16, 0, 0, 1));
        stim_q.push_back(mk(-48, 0, 0, 2));
        stim_q.push_back(mk(2000, 0, 0, 3));
        test_stream("post_reset", 100, 100);
    endtask

    task automatic test_sat_count();
        do_reset();
        for (int i = 0; i < 260; i++)
            stim_q.push_back(mk((i % 2 == 0) ? 1234 : -1234, 1, 0, 0));
        test_stream("sat_count", 100, 100);
        n_cmp++;
        if (sat_count !== 8'd255) begin n_err++; $display("FAIL sat_count_cap: got %0d want 255", sat_count); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        s_overflow = 1'b0;
        relu_en    = 1'b0;
        shift      = 4'd0;
        m_ready    = 1'b0;
        n_cmp      = 0;
        n_err      = 0;
        tb_vec     = 0;
        tb_sat     = 0;
        test_reset();
        test_transform();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_sat_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/act_quant_stage.md
ACT_QUANT_STAGE -- requirements
Module: act_quant_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter VEC_LEN, default 3, results per output vector (for m_last).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  upstream result valid.
REQ-006 s_ready  output  1  stage can accept a result this cycle.
REQ-007 s_data  input  16  signed 16-bit accumulator result y.
REQ-008 s_overflow  input  1  overflow flag accompanying s_data.
REQ-009 relu_en  input  1  clamp negative results to 0; sampled on acceptance.
REQ-010 shift  input  4  arithmetic right-shift amount 0..15; sampled on acceptance.
REQ-011 m_valid  output  1  m_data/m_sat/m_last valid.
REQ-012 m_ready  input  1  downstream accepts this cycle.
REQ-013 m_data  output  8  signed 8-bit quantized activation.
REQ-014 m_sat  output  1  this result was saturated (overflow or clamp).
REQ-015 m_last  output  1  this result is the VEC_LEN-th of its vector.
REQ-016 sat_count  output  8  count of saturated results accepted since reset.

Function
REQ-017 SHALL accept an input on a rising edge where s_valid=1 and s_ready=1; SHALL ignore s_data/s_overflow otherwise (X tolerated).
REQ-018 s_ready SHALL equal (occupancy < DEPTH), from registered occupancy only; no push bypass when full even if a pop occurs same cycle.
REQ-019 Each accepted input SHALL be transformed combinationally and written to the FIFO tail on the accepting edge; m_valid SHALL be 1 the cycle after acceptance if FIFO was empty (latency 1 cycle).
REQ-020 Transform step 1: if s_overflow=1, result = +127 when s_data[15]=1, -128 when s_data[15]=0; sat=1; steps 2-4 skipped.
REQ-021 Step 2: if relu_en=1 and s_data<0, x=0; else x=s_data.
REQ-022 Step 3: r = (x + R) >>> shift in 17-bit signed arithmetic, R = 2^(shift-1) for shift>0, R=0 for shift=0 (round-half-up).
REQ-023 Step 4: r>127 -> 127, r<-128 -> -128, sat=1; else m_data=r[7:0], sat=0.
REQ-024 m_valid SHALL equal (occupancy > 0); head entry SHALL be stable while m_valid=1 and m_ready=0.
REQ-025 Pop SHALL occur on edge with m_valid=1 and m_ready=1; simultaneous push and pop SHALL leave occupancy unchanged; order strictly FIFO.
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy counter SHALL range 0..DEPTH.
REQ-027 Vector counter SHALL increment per accepted input, wrap VEC_LEN-1 -> 0; m_last stored per entry =1 when accepted at count VEC_LEN-1.
REQ-028 sat_count SHALL increment on each accepted input with sat=1, saturate at 255 (no wrap).

Reset
REQ-029 On reset=1 at a rising edge: occupancy, pointers, vector counter, sat_count SHALL be 0; m_valid=0, s_ready=1 the following cycle.
REQ-030 Reset mid-operation SHALL discard all buffered entries; FIFO contents need not be cleared; an input presented with reset=1 SHALL NOT be accepted.
REQ-031 m_data/m_sat/m_last SHALL be don't-care while m_valid=0.

Verification
REQ-032 shift=0, relu_en=0: s_data=100 -> m_data=100, m_sat=0; s_data=186 -> m_data=127, m_sat=1, sat_count=1.
REQ-033 shift=4: s_data=1012 -> 63; 808 -> 51; -494 -> -31; 4191 -> 127 with m_sat=1.
REQ-034 s_overflow=1, s_data=-17149 -> m_data=127, m_sat=1; relu_en=1, s_data=-210 -> m_data=0, m_sat=0.
REQ-035 m_ready=0, offer 5 inputs -> exactly 4 accepted, s_ready=0 after 4th; then m_ready=1 -> 4 outputs in order, m_last=1 on 3rd only, 5th accepted next.
REQ-036 Random s_valid/m_ready over 9 inputs -> 9 outputs in order, m_last on 3rd/6th/9th, no loss or duplication.
REQ-037 Reset with 3 entries buffered -> m_valid=0 next cycle; next 3 inputs give m_last on 3rd.
